vbsc_chain: RTL and testbench
=============================

# vbsc_chain

Parametrised virtual boundary-scan chain for NUM_CELLS bidirectional pads. It sits between the Virtual JTAG instance (tdi/tdo, ir_in, CDR/SDR/UDR virtual states) and the pad I/O buffers. It supports four instruction modes: BYPASS, SAMPLE, EXTEST and CLAMP. It adds a 1-bit bypass register, a synchronous reset, a safe tri-state default and an update-done strobe.

## Interface
Parameters:
- NUM_CELLS, 4, number of scan cells; one cell per pad, 3 bits per cell; legal 1..64.
- CHAIN_LEN, 3*NUM_CELLS, derived scan chain length; not overridable.

Ports:
- tck  in  1  scan/system clock; all state updates on the rising edge.
- trst_n  in  1  synchronous active-low reset.
- tdi  in  1  serial data in from vjtag.
- ir_in  in  2  instruction: 2'b00 BYPASS, 2'b01 SAMPLE, 2'b10 EXTEST, 2'b11 CLAMP.
- cdr  in  1  virtual_state_cdr, level.
- sdr  in  1  virtual_state_sdr, level.
- udr  in  1  virtual_state_udr, one-cycle pulse.
- tdo  out  1  serial data out to vjtag.
- func_out  in  NUM_CELLS  core data to drive on pads.
- func_oe  in  NUM_CELLS  core output enable, active high.
- func_in  out  NUM_CELLS  pad data presented to core.
- pad_in  in  NUM_CELLS  from I/O buffer dataout.
- pad_out  out  NUM_CELLS  to I/O buffer datain.
- pad_oe  out  NUM_CELLS  to I/O buffer, active high (1 = drive).
- upd_done  out  1  one-cycle strobe after an update register load.

## Operation
- Scan-cell register cap[CHAIN_LEN-1:0]. Cell i occupies bit 3i (in), bit 3i+1 (oe) and bit 3i+2 (out).
- Update registers: upd_in, upd_oe, upd_out, NUM_CELLS bits each.
- bypass_reg: 1 bit.
- Selected register:
  - SAMPLE and EXTEST select cap.
  - BYPASS and CLAMP select bypass_reg.
- Capture (cdr=1):
  - cap[3i] <= pad_in[i]; cap[3i+1] <= func_oe[i]; cap[3i+2] <= func_out[i].
  - bypass_reg <= 0.
  - Both capture regardless of mode.
- Shift (sdr=1, cdr=0):
  - If cap is selected: cap <= {tdi, cap[CHAIN_LEN-1:1]}.
  - If bypass_reg is selected: bypass_reg <= tdi.
  - The unselected register holds.
- Priority: cdr over sdr.
- Update (udr=1):
  - In SAMPLE or EXTEST only: upd_in/upd_oe/upd_out[i] <= cap[3i]/cap[3i+1]/cap[3i+2].
  - The registers load from the pre-edge cap value, independent of any concurrent shift.
  - udr in BYPASS or CLAMP: no load and no upd_done.
- Pad mux (combinational on ir_in):
  - EXTEST or CLAMP: pad_out=upd_out, pad_oe=upd_oe, func_in=upd_in.
  - BYPASS or SAMPLE: pad_out=func_out, pad_oe=func_oe, func_in=pad_in.
- tdo:
  - sdr=1: tdo = bit 0 of the selected register (cap[0] or bypass_reg).
  - sdr=0: tdo = 0.
  - tdo is a pure mux of register outputs.
- Reset (trst_n=0 at an edge):
  - cap, bypass_reg and upd_* clear to 0; upd_done is 0.
  - In EXTEST or CLAMP all pads therefore tri-state.
  - Reset overrides cdr, sdr and udr in the same cycle.
  - Reset mid-shift discards the partial shift. The next operation must start with a capture.

## Timing
- Output values after reset:
  - upd_done=0; tdo=0 while sdr=0.
  - In EXTEST or CLAMP: pad_oe=0, pad_out=0, func_in=0.
  - Otherwise the outputs follow the functional inputs.
- Capture edge k with cdr=1. During the first sdr cycle, tdo = captured pad_in[0]. After edge k+n (n shifts), tdo = captured cap[n].
- CHAIN_LEN shift edges fully replace cap. The first tdi bit shifted in ends at cap[0].
- Bypass path: 1 cycle of tdi-to-tdo delay.
- Update:
  - Edge u (udr=1): upd_* load; pad outputs in EXTEST change immediately after edge u.
  - upd_done=1 for exactly the cycle after edge u.
- Mode change on ir_in: the pad mux switches combinationally in the same cycle; no register is disturbed.
- Shift longer than CHAIN_LEN: bits fall off cap[0] (to tdo). No wrap and no error.

## Test plan
- Reset with ir_in=EXTEST, func_oe=4'hF, func_out=4'hF → pad_oe=4'h0, pad_out=4'h0, upd_done=0.
- SAMPLE: pad_in=4'b0101, func_oe=4'b0011, func_out=4'b1001. Capture, then 12 shifts → tdo bit sequence 1,1,1, 0,1,0, 1,0,0, 0,0,1.
- EXTEST, NUM_CELLS=4: shift 12'hABC LSB first, then pulse udr →
  - pad_out=4'b1011, pad_oe=4'b0110, func_in=4'b1010;
  - upd_done high for one cycle.
- BYPASS: capture, then shift tdi=1,0,1,1 → tdo=0,1,0,1; cap unchanged; udr gives no upd_done.
- CLAMP after the EXTEST load above: shift 8 bits through bypass → pad_out stays 4'b1011 and pad_oe stays 4'b0110 throughout.
- Assert trst_n=0 after 5 of 12 shifts in EXTEST → pads tri-state at once. A new capture plus 12 shifts plus update then loads correctly.

Source files
------------

// File: rtl/vbsc_chain_if.sv
// vbsc_chain_if: virtual JTAG side of the boundary-scan chain
// Ports: tdi, ir_in, cdr, sdr, udr from the vjtag instance; tdo and upd_done back to it.
// master = vjtag side, slave = scan chain.
interface vbsc_chain_if;
    logic       tdi;
    logic [1:0] ir_in;
    logic       cdr;
    logic       sdr;
    logic       udr;
    logic       tdo;
    logic       upd_done;
    modport master(output tdi, ir_in, cdr, sdr, udr, input tdo, upd_done);
    modport slave(input tdi, ir_in, cdr, sdr, udr, output tdo, upd_done);
endinterface

// File: rtl/vbsc_chain.sv
// vbsc_chain: virtual boundary-scan chain with BYPASS/SAMPLE/EXTEST/CLAMP over NUM_CELLS pads
// Ports: tck/trst_n clock and sync active-low reset; jtag bundles the vjtag handshake;
// func_out/func_oe from core, func_in to core; pad_in from I/O buffer, pad_out/pad_oe to it.
module vbsc_chain #(
    parameter int NUM_CELLS = 4
) (
    input  logic                 tck,
    input  logic                 trst_n,
    vbsc_chain_if.slave          jtag,
    input  logic [NUM_CELLS-1:0] func_out,
    input  logic [NUM_CELLS-1:0] func_oe,
    output logic [NUM_CELLS-1:0] func_in,
    input  logic [NUM_CELLS-1:0] pad_in,
    output logic [NUM_CELLS-1:0] pad_out,
    output logic [NUM_CELLS-1:0] pad_oe
);
    localparam int CHAIN_LEN = 3 * NUM_CELLS;
    logic [CHAIN_LEN-1:0] cap;
    logic [CHAIN_LEN-1:0] cap_val;
    logic [NUM_CELLS-1:0] upd_in;
    logic [NUM_CELLS-1:0] upd_oe;
    logic [NUM_CELLS-1:0] upd_out;
    logic                 bypass_reg;
    logic                 sel_cap;
    logic                 drive_upd;
    // SAMPLE (01) and EXTEST (10) select cap; BYPASS (00) and CLAMP (11) select bypass_reg
    assign sel_cap   = ^jtag.ir_in;
    // EXTEST and CLAMP both drive pads from the update registers
    assign drive_upd = jtag.ir_in[1];
    always_comb begin
        cap_val = '0;
        for (int i = 0; i < NUM_CELLS; i++)
            cap_val[3*i +: 3] = {func_out[i], func_oe[i], pad_in[i]};
    end
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            cap           <= '0;
            bypass_reg    <= 1'b0;
            upd_in        <= '0;
            upd_oe        <= '0;
            upd_out       <= '0;
            jtag.upd_done <= 1'b0;
        end else begin
            jtag.upd_done <= jtag.udr && sel_cap;
            if (jtag.cdr) begin
                cap        <= cap_val;
                bypass_reg <= 1'b0;
            end else if (jtag.sdr) begin
                if (sel_cap)
                    cap <= {jtag.tdi, cap[CHAIN_LEN-1:1]};
                else
                    bypass_reg <= jtag.tdi;
            end
            // non-blocking reads of cap give the pre-edge value even during a shift
            if (jtag.udr && sel_cap) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    upd_in[i]  <= cap[3*i];
                    upd_oe[i]  <= cap[3*i+1];
                    upd_out[i] <= cap[3*i+2];
                end
            end
        end
    end
    assign jtag.tdo = jtag.sdr ? (sel_cap ? cap[0] : bypass_reg) : 1'b0;
    assign pad_out  = drive_upd ? upd_out : func_out;
    assign pad_oe   = drive_upd ? upd_oe  : func_oe;
    assign func_in  = drive_upd ? upd_in  : pad_in;
endmodule

// File: tb/tb_vbsc_chain.sv
// tb_vbsc_chain: directed self-checking bench for vbsc_chain (NUM_CELLS=4)
module tb_vbsc_chain;
    localparam logic [1:0] BYPASS = 2'b00;
    localparam logic [1:0] SAMPLE = 2'b01;
    localparam logic [1:0] EXTEST = 2'b10;
    localparam logic [1:0] CLAMP  = 2'b11;

    logic       tck = 1'b0;
    logic       trst_n;
    logic [3:0] func_out;
    logic [3:0] func_oe;
    logic [3:0] func_in;
    logic [3:0] pad_in;
    logic [3:0] pad_out;
    logic [3:0] pad_oe;
    int         total = 0;
    int         bad = 0;

    vbsc_chain_if jtag();

    vbsc_chain #(.NUM_CELLS(4)) dut (
        .tck(tck),
        .trst_n(trst_n),
        .jtag(jtag),
        .func_out(func_out),
        .func_oe(func_oe),
        .func_in(func_in),
        .pad_in(pad_in),
        .pad_out(pad_out),
        .pad_oe(pad_oe)
    );

    always #5 tck = ~tck;

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    task automatic test_reset;
        trst_n = 1'b0;
        jtag.ir_in = EXTEST;
        jtag.tdi = 1'b0;
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b0;
        jtag.udr = 1'b1;
        func_oe = 4'hF;
        func_out = 4'hF;
        pad_in = 4'hF;
        tick();
        tick();
        @(negedge tck);
        total++; if (pad_oe !== 4'h0) begin bad++; $display("FAIL reset pad_oe got=%h want=0", pad_oe); end
        total++; if (pad_out !== 4'h0) begin bad++; $display("FAIL reset pad_out got=%h want=0", pad_out); end
        total++; if (func_in !== 4'h0) begin bad++; $display("FAIL reset func_in got=%h want=0", func_in); end
        total++; if (jtag.upd_done !== 1'b0) begin bad++; $display("FAIL reset upd_done got=%b want=0", jtag.upd_done); end
        total++; if (jtag.tdo !== 1'b0) begin bad++; $display("FAIL reset tdo got=%b want=0", jtag.tdo); end
        jtag.udr = 1'b0;
        trst_n = 1'b1;
        jtag.ir_in = SAMPLE;
        #1;
        total++; if (pad_oe !== 4'hF || pad_out !== 4'hF || func_in !== 4'hF)
            begin bad++; $display("FAIL mode_switch pads got oe=%h out=%h in=%h want=f/f/f", pad_oe, pad_out, func_in); end
        tick();
    endtask

    task automatic test_sample;
        logic [11:0] exp_seq;
        exp_seq = 12'b1000_0101_0111;
        jtag.ir_in = SAMPLE;
        pad_in = 4'b0101;
        func_oe = 4'b0011;
        func_out = 4'b1001;
        jtag.cdr = 1'b1;
        tick();
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge tck);
            total++; if (jtag.tdo !== exp_seq[i]) begin bad++; $display("FAIL sample_tdo[%0d] got=%b want=%b", i, jtag.tdo, exp_seq[i]); end
            tick();
        end
        jtag.sdr = 1'b0;
        @(negedge tck);
        total++; if (jtag.tdo !== 1'b0) begin bad++; $display("FAIL sample_tdo_idle got=%b want=0", jtag.tdo); end
    endtask

    task automatic test_extest;
        logic [11:0] v;
        v = 12'hABC;
        jtag.ir_in = EXTEST;
        jtag.cdr = 1'b1;
        tick();
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            jtag.tdi = v[i];
            tick();
        end
        jtag.sdr = 1'b0;
        @(negedge tck);
        total++; if (pad_oe !== 4'h0) begin bad++; $display("FAIL extest_pre_update pad_oe got=%h want=0", pad_oe); end
        jtag.udr = 1'b1;
        tick();
        jtag.udr = 1'b0;
        @(negedge tck);
        total++; if (pad_out !== 4'b1011) begin bad++; $display("FAIL extest pad_out got=%b want=1011", pad_out); end
        total++; if (pad_oe !== 4'b0110) begin bad++; $display("FAIL extest pad_oe got=%b want=0110", pad_oe); end
        total++; if (func_in !== 4'b1010) begin bad++; $display("FAIL extest func_in got=%b want=1010", func_in); end
        total++; if (jtag.upd_done !== 1'b1) begin bad++; $display("FAIL extest upd_done got=%b want=1", jtag.upd_done); end
        tick();
        @(negedge tck);
        total++; if (jtag.upd_done !== 1'b0) begin bad++; $display("FAIL extest upd_done_drop got=%b want=0", jtag.upd_done); end
    endtask

    task automatic test_bypass;
        logic [3:0] din;
        logic [3:0] dout;
        din = 4'b1101;
        dout = 4'b1010;
        jtag.ir_in = BYPASS;
        jtag.cdr = 1'b1;
        tick();
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            jtag.tdi = din[i];
            @(negedge tck);
            total++; if (jtag.tdo !== dout[i]) begin bad++; $display("FAIL bypass_tdo[%0d] got=%b want=%b", i, jtag.tdo, dout[i]); end
            tick();
        end
        jtag.sdr = 1'b0;
        total++; if (dut.cap !== 12'h857) begin bad++; $display("FAIL bypass_cap got=%h want=857", dut.cap); end
        jtag.udr = 1'b1;
        tick();
        jtag.udr = 1'b0;
        @(negedge tck);
        total++; if (jtag.upd_done !== 1'b0) begin bad++; $display("FAIL bypass_upd_done got=%b want=0", jtag.upd_done); end
    endtask

    task automatic test_clamp;
        logic [7:0] din;
        logic       prev;
        din = 8'b1011_0010;
        prev = 1'b0;
        jtag.ir_in = CLAMP;
        jtag.cdr = 1'b1;
        tick();
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            jtag.tdi = din[i];
            @(negedge tck);
            total++; if (pad_out !== 4'b1011 || pad_oe !== 4'b0110 || func_in !== 4'b1010)
                begin bad++; $display("FAIL clamp_pads[%0d] got out=%b oe=%b in=%b want 1011/0110/1010", i, pad_out, pad_oe, func_in); end
            total++; if (jtag.tdo !== prev) begin bad++; $display("FAIL clamp_tdo[%0d] got=%b want=%b", i, jtag.tdo, prev); end
            prev = din[i];
            tick();
        end
        jtag.sdr = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        logic [11:0] v;
        v = 12'h5A3;
        jtag.ir_in = EXTEST;
        jtag.cdr = 1'b1;
        tick();
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jtag.tdi = 1'b1;
            tick();
        end
        trst_n = 1'b0;
        jtag.udr = 1'b1;
        tick();
        jtag.udr = 1'b0;
        jtag.sdr = 1'b0;
        @(negedge tck);
        total++; if (pad_oe !== 4'h0 || pad_out !== 4'h0 || func_in !== 4'h0)
            begin bad++; $display("FAIL midreset_pads got oe=%h out=%h in=%h want 0/0/0", pad_oe, pad_out, func_in); end
        total++; if (jtag.upd_done !== 1'b0) begin bad++; $display("FAIL midreset_upd_done got=%b want=0", jtag.upd_done); end
        trst_n = 1'b1;
        jtag.cdr = 1'b1;
        tick();
        jtag.cdr = 1'b0;
        jtag.sdr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            jtag.tdi = v[i];
            tick();
        end
        jtag.sdr = 1'b0;
        jtag.udr = 1'b1;
        tick();
        jtag.udr = 1'b0;
        @(negedge tck);
        total++; if (pad_out !== 4'b0110) begin bad++; $display("FAIL reload pad_out got=%b want=0110", pad_out); end
        total++; if (pad_oe !== 4'b1101) begin bad++; $display("FAIL reload pad_oe got=%b want=1101", pad_oe); end
        total++; if (func_in !== 4'b0001) begin bad++; $display("FAIL reload func_in got=%b want=0001", func_in); end
        total++; if (jtag.upd_done !== 1'b1) begin bad++; $display("FAIL reload upd_done got=%b want=1", jtag.upd_done); end
    endtask

    initial begin
        test_reset();
        test_sample();
        test_extest();
        test_bypass();
        test_clamp();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
